// File: rtl/otter_arb_pkg.sv
// Shared types and constants for the OTTER single-port memory arbiter.
package otter_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } rsp_owner_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // One memory-port transaction as seen by the macro.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
  } mem_req_t;

endpackage

// File: rtl/otter_arb_starve_ctr.sv
// Saturating count of consecutive denied fetch cycles; fire forces a fetch grant
// once the count reaches MAX_WAIT while both requesters are waiting.
module otter_arb_starve_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic if_req,
  input  logic d_req,
  input  logic if_gnt,
  output logic fire
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                      wait_cnt <= '0;
    else if (!if_req || if_gnt)   wait_cnt <= '0;
    else if (wait_cnt != CW'(MAX_WAIT)) wait_cnt <= wait_cnt + CW'(1);
  end

  assign fire = (wait_cnt == CW'(MAX_WAIT)) & if_req & d_req;

endmodule

// File: rtl/otter_mem_arbiter.sv
// Fetch/data arbiter for one synchronous memory port (1-cycle read latency).
// Define OTTER_ARB_STARVE_GUARD_EN to add the fetch starvation guard.
module otter_mem_arbiter
  import otter_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  input  logic        d_sign,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_sign,
  input  logic [31:0] mem_rdata
);

  logic       fire;
  rsp_owner_t rsp_owner;
  logic [31:0] if_hold;
  mem_req_t   mreq;

`ifdef OTTER_ARB_STARVE_GUARD_EN
  otter_arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .CLK    (CLK),
    .RST    (RST),
    .if_req (if_req),
    .d_req  (d_req),
    .if_gnt (if_gnt),
    .fire   (fire)
  );
`else
  localparam int unused_max_wait = MAX_WAIT;
  assign fire = 1'b0;
`endif

  // fire already implies if_req, so the fall-through hands the port to fetch.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!RST) begin
      if (d_req && !fire) d_gnt  = 1'b1;
      else if (if_req)    if_gnt = 1'b1;
    end
  end

  always_comb begin
    mreq = '0;
    if (d_gnt) begin
      mreq.we    = d_we;
      mreq.addr  = d_addr;
      mreq.wdata = d_wdata;
      mreq.size  = d_size;
      mreq.sign  = d_sign;
    end else if (if_gnt) begin
      mreq.addr  = if_addr;
      mreq.size  = SZ_WORD;
    end
  end

  assign mem_en    = if_gnt | d_gnt;
  assign mem_we    = mreq.we;
  assign mem_addr  = mreq.addr;
  assign mem_wdata = mreq.wdata;
  assign mem_size  = mreq.size;
  assign mem_sign  = mreq.sign;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                rsp_owner <= OWN_NONE;
    else if (if_gnt)        rsp_owner <= OWN_IF;
    else if (d_gnt && !d_we) rsp_owner <= OWN_D;
    else                    rsp_owner <= OWN_NONE;
  end

  assign if_rvalid = (rsp_owner == OWN_IF);
  assign d_rvalid  = (rsp_owner == OWN_D);

  // A stalled fetch stage keeps seeing its last instruction.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            if_hold <= '0;
    else if (if_rvalid) if_hold <= mem_rdata;
  end

  assign if_rdata = if_rvalid ? mem_rdata : if_hold;
  assign d_rdata  = d_rvalid  ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Self-checking bench: directed cases plus randomized traffic against a behavioural model.
module tb_otter_mem_arbiter;

  localparam int MW = 4;
`ifdef OTTER_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_sign, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_size;
  logic        mem_en, mem_we, mem_sign;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  otter_mem_arbiter #(.MAX_WAIT(MW)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .d_sign(d_sign), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_sign(mem_sign),
    .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model: m_wait = consecutive denied fetch cycles, m_pend = who gets data this cycle
  // (0 none, 1 fetch, 2 data), m_hold = last instruction delivered to fetch.
  int          m_wait;
  int          m_pend;
  logic [31:0] m_hold;

  function automatic void exp_gnt(output bit eif, output bit ed);
    eif = 1'b0;
    ed  = 1'b0;
    if (RST !== 1'b0) return;
    if (d_req && !(GUARD && if_req && m_wait >= MW)) ed = 1'b1;
    else if (if_req) eif = 1'b1;
  endfunction

  always @(posedge CLK or posedge RST) begin
    bit eif, ed;
    if (RST) begin
      m_wait = 0;
      m_pend = 0;
      m_hold = 32'h0;
    end else begin
      exp_gnt(eif, ed);
      if (m_pend == 1) m_hold = mem_rdata;
      m_pend = eif ? 1 : ((ed && !d_we) ? 2 : 0);
      if (!if_req || eif) m_wait = 0;
      else if (m_wait < MW) m_wait++;
    end
  end

  always @(negedge CLK) begin
    bit eif, ed;
    if (chk_en) begin
      exp_gnt(eif, ed);
      chk("if_gnt", 32'(if_gnt), 32'(eif));
      chk("d_gnt",  32'(d_gnt),  32'(ed));
      chk("mem_en", 32'(mem_en), 32'(eif | ed));
      if (ed) begin
        chk("mem_we_d",    32'(mem_we),   32'(d_we));
        chk("mem_addr_d",  mem_addr,      d_addr);
        chk("mem_wdata_d", mem_wdata,     d_wdata);
        chk("mem_size_d",  32'(mem_size), 32'(d_size));
        chk("mem_sign_d",  32'(mem_sign), 32'(d_sign));
      end else if (eif) begin
        chk("mem_we_if",   32'(mem_we),   32'd0);
        chk("mem_addr_if", mem_addr,      if_addr);
        chk("mem_size_if", 32'(mem_size), 32'd2);
        chk("mem_sign_if", 32'(mem_sign), 32'd0);
      end else begin
        chk("mem_idle", {mem_addr ^ mem_wdata}, 32'h0);
        chk("mem_idle_addr", mem_addr, 32'h0);
        chk("mem_idle_ctl", {29'd0, mem_we, mem_size}, 32'h0);
        chk("mem_idle_sign", 32'(mem_sign), 32'd0);
      end
      chk("if_rvalid", 32'(if_rvalid), 32'(m_pend == 1));
      chk("d_rvalid",  32'(d_rvalid),  32'(m_pend == 2));
      chk("if_rdata",  if_rdata, (m_pend == 1) ? mem_rdata : m_hold);
      chk("d_rdata",   d_rdata,  (m_pend == 2) ? mem_rdata : 32'h0);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
    d_addr = 0; d_wdata = 0; d_size = 0; d_sign = 0;
  endtask

  initial begin
    RST = 1'b1;
    idle();
    mem_rdata = 32'h0;
    if_req = 1; d_req = 1;
    chk_en = 1'b1;
    @(negedge CLK);
    chk("rst_gnt", {30'd0, if_gnt, d_gnt}, 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'h0);
    chk("rst_rdata", if_rdata | d_rdata, 32'h0);

    // Fetch only, first cycle out of reset
    step();
    RST = 1'b0; idle();
    if_req = 1; if_addr = 32'h100;
    @(negedge CLK);
    chk("fetch_gnt", 32'(if_gnt), 32'd1);
    chk("fetch_addr", mem_addr, 32'h100);
    step();
    if_req = 0; mem_rdata = 32'h00A00093;
    @(negedge CLK);
    chk("fetch_rvalid", 32'(if_rvalid), 32'd1);
    chk("fetch_rdata", if_rdata, 32'h00A00093);
    step();
    mem_rdata = 32'h12345678;
    @(negedge CLK);
    chk("fetch_hold_rvalid", 32'(if_rvalid), 32'd0);
    chk("fetch_hold", if_rdata, 32'h00A00093);

    // Contention: data load wins
    step();
    if_req = 1; if_addr = 32'h104;
    d_req = 1; d_we = 0; d_addr = 32'h2000; d_size = 2;
    @(negedge CLK);
    chk("cont_d_gnt", 32'(d_gnt), 32'd1);
    chk("cont_if_gnt", 32'(if_gnt), 32'd0);
    step();
    idle(); mem_rdata = 32'hCAFEF00D;
    @(negedge CLK);
    chk("cont_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("cont_d_rdata", d_rdata, 32'hCAFEF00D);
    chk("cont_if_rvalid", 32'(if_rvalid), 32'd0);

    // Store: no response
    step();
    d_req = 1; d_we = 1; d_addr = 32'h11000000; d_wdata = 32'hDEADBEEF; d_size = 2;
    mem_rdata = 32'h0;
    @(negedge CLK);
    chk("st_mem_we", 32'(mem_we), 32'd1);
    chk("st_wdata", mem_wdata, 32'hDEADBEEF);
    step();
    idle(); mem_rdata = 32'h55AA55AA;
    @(negedge CLK);
    chk("st_no_rvalid", 32'(d_rvalid), 32'd0);
    chk("st_d_rdata", d_rdata, 32'h0);

    // Starvation: both held high for 20 cycles
    for (int i = 0; i < 20; i++) begin
      step();
      if_req = 1; if_addr = 32'h108; d_req = 1; d_we = 0; d_addr = 32'h3000; d_size = 2;
      mem_rdata = $urandom;
      @(negedge CLK);
      chk("starve_if_gnt", 32'(if_gnt), 32'(GUARD && (i % 5 == 4)));
      chk("starve_d_gnt", 32'(d_gnt), 32'(!(GUARD && (i % 5 == 4))));
    end

    // Reset mid-read drops the pending fetch response
    step();
    idle(); if_req = 1; if_addr = 32'h200;
    @(negedge CLK);
    chk("rmr_gnt", 32'(if_gnt), 32'd1);
    @(posedge CLK);
    #1 RST = 1'b1;
    #1 RST = 1'b0;
    idle(); mem_rdata = 32'h0BADF00D;
    @(negedge CLK);
    chk("rmr_rvalid", 32'(if_rvalid), 32'd0);
    chk("rmr_rdata", if_rdata, 32'h0);

    // Reset clears a partially counted wait
    step();
    if_req = 1; d_req = 1; d_we = 1; d_addr = 32'h40;
    step();
    @(posedge CLK);
    #1 RST = 1'b1;
    #1 RST = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      @(negedge CLK);
      chk("rwait_if_gnt", 32'(if_gnt), 32'(GUARD && (i == 4)));
    end

    // Randomized traffic, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      step();
      RST = ($urandom_range(0, 99) == 0);
      if (!RST && $urandom_range(0, 80) == 0) begin
        RST = 1'b1;
        #1 RST = 1'b0;
      end
      if_req  = ($urandom_range(0, 3) != 0);
      if_addr = $urandom & 32'hFFFF_FFFC;
      d_req   = ($urandom_range(0, 2) != 0);
      d_we    = $urandom_range(0, 1);
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_size  = 2'($urandom_range(0, 2));
      d_sign  = $urandom_range(0, 1);
      mem_rdata = $urandom;
    end
    step();
    RST = 1'b0;
    @(negedge CLK);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/otter_mem_arbiter.md
# otter_mem_arbiter

Single-port memory arbiter for the pipelined OTTER core. It lets the instruction-fetch stage and the data (load/store/IOBUS-mapped) stage share one synchronous memory port with a fixed 1-cycle read latency. It sits between the fetch/memory pipeline stages and the memory macro. Data accesses win by default, and fetch is stalled through its grant. Read responses are steered back to the requester that issued them.

## Interface
- `MAX_WAIT`, default 4: consecutive denied fetch cycles before fetch is forced to win; legal range 1..15.
- `CLK` in 1: clock; all state updates on rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `if_req` in 1: fetch requests a word read.
- `if_addr` in 32: fetch word address.
- `if_gnt` out 1: fetch request accepted this cycle.
- `if_rvalid` out 1: fetch read data valid.
- `if_rdata` out 32: fetch read data, held until the next `if_rvalid`.
- `d_req` in 1: data access request.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_size` in 2: 0 = byte, 1 = half, 2 = word.
- `d_sign` in 1: load sign-extend.
- `d_gnt` out 1: data request accepted this cycle.
- `d_rvalid` out 1: load data valid.
- `d_rdata` out 32: load data.
- `mem_en`, `mem_we` out 1: memory port enable and write enable.
- `mem_addr`, `mem_wdata` out 32: memory address and write data.
- `mem_size` out 2, `mem_sign` out 1: access size and sign to the memory.
- `mem_rdata` in 32: memory read data, valid the cycle after a read enable.

## Operation
- **Grant (combinational from requests and state):**
  - Only `d_req`: data wins.
  - Only `if_req`: fetch wins.
  - Both: data wins, unless the starvation guard fires; then fetch wins.
  - At most one grant is high per cycle.
  - While `RST` is high, both grants and `mem_en` are 0.
- **Memory drive:** the granted requester's signals are muxed onto `mem_*`, and `mem_en` = `if_gnt | d_gnt`.
  - A fetch grant drives `mem_we` = 0, `mem_size` = 2, `mem_sign` = 0.
  - With no grant, `mem_addr`, `mem_wdata`, `mem_size` and `mem_sign` are 0.
- **Response owner register `rsp_owner` ∈ {NONE, IF, D}, updated every edge:**
  - IF if `if_gnt`.
  - D if `d_gnt & !d_we`.
  - Otherwise NONE (stores and idle cycles produce no response).
- **Response outputs:**
  - `if_rvalid` = (`rsp_owner` == IF); `d_rvalid` = (`rsp_owner` == D).
  - `d_rdata` = `mem_rdata` when `d_rvalid`, else 0.
  - `if_rdata` = `mem_rdata` when `if_rvalid`, else `if_hold`. `if_hold` captures `mem_rdata` on every `if_rvalid` cycle, so a stalled fetch keeps its instruction.
- **Starvation counter `wait_cnt`, width `$clog2(MAX_WAIT+1)`:**
  - Increments when `if_req & !if_gnt`, saturating at `MAX_WAIT`.
  - Clears when `if_gnt` or `!if_req`.
  - The guard fires when `wait_cnt == MAX_WAIT` and both requests are high.
- Requesters must hold their request and payload stable until granted. The arbiter does not check this.

## Timing
- Grant has 0-cycle latency (same cycle as the request). Read data has 1-cycle latency after the grant.
- Back-to-back grants are allowed every cycle, to either requester, with no bubble.
- **Reset values:**
  - `rsp_owner` = NONE, `wait_cnt` = 0, `if_hold` = 0.
  - All `rvalid` outputs are 0, and both `rdata` outputs are 0.
- `RST` asserted mid-access: the pending response is dropped, with no `rvalid` after reset release. The first grant can occur in the first cycle with `RST` low.
- Simultaneous requests on the cycle the guard fires:
  - Fetch is granted and `wait_cnt` clears.
  - The next cycle returns to data priority.

## Configuration
- `OTTER_ARB_STARVE_GUARD_EN` defined: the starvation counter and forced fetch grant are present, as above.
- Not defined: strict data priority. `wait_cnt` logic is omitted and `MAX_WAIT` is ignored.

## Structure
- Shared package `otter_arb_pkg` holds:
  - `rsp_owner_t` enum {`OWN_NONE`, `OWN_IF`, `OWN_D`}.
  - Size constants `SZ_BYTE` = 0, `SZ_HALF` = 1, `SZ_WORD` = 2.
- One sub-module, `otter_arb_starve_ctr`, holds the saturating counter and fire output. It is instantiated only under `OTTER_ARB_STARVE_GUARD_EN`.

## Test plan
- **Fetch only:** `if_req` = 1, `if_addr` = 0x100, `mem_rdata` = 0x00A00093 next cycle.
  - `if_gnt` = 1 in the same cycle; `if_rvalid` = 1 and `if_rdata` = 0x00A00093 the following cycle.
  - With `if_req` then dropped, `if_rdata` holds 0x00A00093.
- **Contention:** `if_req` = `d_req` = 1 with a load at 0x2000.
  - `d_gnt` = 1 and `if_gnt` = 0; `d_rvalid` follows one cycle later and `if_rvalid` = 0.
- **Store:** `d_req`, `d_we` = 1, `d_addr` = 0x11000000, `d_wdata` = 0xDEADBEEF, `d_size` = 2.
  - `mem_we` = 1, `mem_wdata` = 0xDEADBEEF; no `d_rvalid` the next cycle.
- **Starvation with guard, `MAX_WAIT` = 4:** both requests held high continuously.
  - `d_gnt` for 4 cycles, `if_gnt` on the 5th, then the pattern repeats.
- **Starvation without guard:** same stimulus; `if_gnt` stays 0 for 20 cycles.
- **Reset mid-read:** a fetch is granted, then `RST` pulses asynchronously before the next edge.
  - `if_rvalid` never rises, `if_rdata` = 0, and `wait_cnt` = 0 after release.
